// File: rtl/half_adder.sv
// half_adder: one-bit half adder with live sum/carry, a registered copy of
// both results, and a saturating count of clock edges that saw a carry.
// The combinational outputs never depend on clk or rst_n, so adder-chain
// benches can sample them immediately or use the registered copies a cycle later.

module half_adder #(
   parameter int CNT_W = 8            // carry-event counter width, 1..32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x,
   input  logic             y,
   output logic             S,
   output logic             C,
   output logic             S_q,
   output logic             C_q,
   output logic [CNT_W-1:0] carry_cnt
);

   // Counter value at which counting stops instead of wrapping.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic s_next;
   logic c_next;
   logic cnt_inc;

   // Gate-level sum and carry. Plain XOR/AND so an unknown input propagates
   // with normal gate semantics (0 AND X is 0, anything XOR X is X).
   assign s_next = x ^ y;
   assign c_next = x & y;
   assign S      = s_next;
   assign C      = c_next;

   // Count only a definite carry; an unknown carry must not advance the count,
   // and the all-ones value is sticky.
   assign cnt_inc = (c_next === 1'b1) && (carry_cnt != CNT_MAX);

   // Registered copy of sum and carry, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S_q <= 1'b0;
         C_q <= 1'b0;
      end else begin
         S_q <= s_next;
         C_q <= c_next;
      end
   end

   // Saturating carry-event counter, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_cnt <= '0;
      end else if (cnt_inc) begin
         carry_cnt <= carry_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed and randomized checks of half_adder against a
// behavioural model. Two instances share the inputs: one with the default
// 8-bit counter and one with a 2-bit counter so saturation is reachable.

module tb_half_adder;

   logic       clk    = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst_n  = 1'b1;
   logic       x      = 1'b0;
   logic       y      = 1'b0;

   logic       s_a, c_a, sq_a, cq_a;
   logic [7:0] cnt_a;
   logic       s_b, c_b, sq_b, cq_b;
   logic [1:0] cnt_b;

   int total   = 0;
   int bad     = 0;
   bit chk_on  = 1'b0;

   // Model state: what the registered outputs must hold right now.
   bit m_sq    = 1'b0;
   bit m_cq    = 1'b0;
   int m_cnt_a = 0;
   int m_cnt_b = 0;

   half_adder #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y),
      .S(s_a), .C(c_a), .S_q(sq_a), .C_q(cq_a), .carry_cnt(cnt_a)
   );

   half_adder #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y),
      .S(s_b), .C(c_b), .S_q(sq_b), .C_q(cq_b), .carry_cnt(cnt_b)
   );

   // 10 ns clock that can be held still for the unclocked sweep.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // Behavioural model: arithmetic sum of the two bits gives carry and sum;
   // counters are plain integers capped at their maximum.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sq    = 1'b0;
         m_cq    = 1'b0;
         m_cnt_a = 0;
         m_cnt_b = 0;
      end else begin
         int tot;
         tot  = int'(x === 1'b1) + int'(y === 1'b1);
         m_sq = (tot == 1);
         m_cq = (tot == 2);
         if (tot == 2 && m_cnt_a < 255) m_cnt_a = m_cnt_a + 1;
         if (tot == 2 && m_cnt_b < 3)   m_cnt_b = m_cnt_b + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every falling edge in the clocked phase: compare both instances to the model.
   always @(negedge clk) begin
      if (chk_on) begin
         int tot;
         tot = int'(x) + int'(y);
         chk("S",       32'(s_a),   32'(tot == 1));
         chk("C",       32'(c_a),   32'(tot == 2));
         chk("S_q",     32'(sq_a),  32'(m_sq));
         chk("C_q",     32'(cq_a),  32'(m_cq));
         chk("cnt",     32'(cnt_a), 32'(m_cnt_a));
         chk("S_q_sat", 32'(sq_b),  32'(m_sq));
         chk("C_q_sat", 32'(cq_b),  32'(m_cq));
         chk("cnt_sat", 32'(cnt_b), 32'(m_cnt_b));
      end
   end

   // Hard stop in case something never returns.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] pat;
      logic [1:0] exp_sc [4];
      exp_sc[0] = 2'b00; exp_sc[1] = 2'b10; exp_sc[2] = 2'b10; exp_sc[3] = 2'b01;

      // Reset without a clock.
      #1 rst_n = 1'b0;
      #1;
      chk("rst_S_q",  32'(sq_a),  32'd0);
      chk("rst_C_q",  32'(cq_a),  32'd0);
      chk("rst_cnt",  32'(cnt_a), 32'd0);

      // Combinational truth table, clock stopped, checked 10 ns after each apply.
      for (int i = 0; i < 4; i++) begin
         pat = 2'(i);
         x = pat[1];
         y = pat[0];
         #10;
         chk("comb_S", 32'(s_a), 32'(exp_sc[i][1]));
         chk("comb_C", 32'(c_a), 32'(exp_sc[i][0]));
      end

      // Unknown propagation (gate semantics).
      x = 1'b1; y = 1'bx;
      #10;
      chk("x1_S", 32'(s_a), 32'(x ^ y));
      chk("x1_C", 32'(c_a), 32'(x & y));
      x = 1'b0;
      #10;
      chk("x0_C", 32'(c_a), 32'd0);
      chk("x0_S", 32'(s_a), 32'(x ^ y));

      // Start the clock and leave reset with quiet inputs.
      x = 1'b0; y = 1'b0;
      rst_n  = 1'b1;
      clk_en = 1'b1;
      chk_on = 1'b1;
      @(negedge clk); #1;

      // Registered path: 11 then 01.
      x = 1'b1; y = 1'b1;
      @(negedge clk);
      chk("reg1_S_q", 32'(sq_a), 32'd0);
      chk("reg1_C_q", 32'(cq_a), 32'd1);
      #1 x = 1'b0; y = 1'b1;
      @(negedge clk);
      chk("reg2_S_q", 32'(sq_a), 32'd1);
      chk("reg2_C_q", 32'(cq_a), 32'd0);
      chk("reg2_cnt", 32'(cnt_a), 32'd1);

      // Build the count up to 5 with C_q=1, then reset between edges.
      #1 x = 1'b1; y = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_rst_cnt", 32'(cnt_a), 32'd5);
      chk("pre_rst_C_q", 32'(cq_a),  32'd1);
      chk("model_cnt5",  32'(m_cnt_a), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_S_q",    32'(sq_a),  32'd0);
      chk("arst_C_q",    32'(cq_a),  32'd0);
      chk("arst_cnt",    32'(cnt_a), 32'd0);
      chk("arst_cnt_sat",32'(cnt_b), 32'd0);
      chk("arst_S_live", 32'(s_a),   32'd0);
      chk("arst_C_live", 32'(c_a),   32'd1);
      x = 1'b0;
      #1;
      chk("arst_S_live2", 32'(s_a),  32'd1);
      chk("arst_C_live2", 32'(c_a),  32'd0);

      // Saturation on the 2-bit counter: 1,2,3,3,3,3.
      @(negedge clk); #1;
      rst_n = 1'b1;
      x = 1'b1; y = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("sat_cnt", 32'(cnt_b), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      chk("model_sat", 32'(m_cnt_b), 32'd3);

      // Counter idle with x=1, y=0 after a fresh reset.
      #1 rst_n = 1'b0;
      x = 1'b1; y = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("idle_cnt", 32'(cnt_a), 32'd0);
         chk("idle_C_q", 32'(cq_a),  32'd0);
      end

      // Randomized inputs with occasional asynchronous reset pulses.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         x     = 1'($urandom);
         y     = 1'($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 39) != 0);
      end
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
